// File: rtl/shiftdist_pipe.sv
// Normalisation shift-distance unit for the rounder's significand shifter.
// Two-stage valid/ready pipeline: S1 adds the exponent bias, S2 selects and clamps.
module shiftdist_pipe #(
    parameter int EW   = 13,
    parameter int LZW  = 6,
    parameter int SIGW = 53,
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [EW-1:0]   er,
    input  logic [LZW-1:0]  lz,
    input  logic            db,
    input  logic            tiny,
    input  logic            unfen,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [EW-1:0]   sh,
    output logic            sh_sat,
    output logic [TAGW-1:0] out_tag
);

    // Most negative right shift that still leaves the guard and sticky positions meaningful.
    localparam int            CLAMP_I = -(SIGW + 2);
    localparam logic [EW-1:0] CLAMP   = CLAMP_I[EW-1:0];

    // Stage 1 registers
    logic            v1_q,   v1_d;
    logic [EW-1:0]   sum_q,  sum_d;
    logic            den_q,  den_d;
    logic [EW-1:0]   lz_q,   lz_d;
    logic [TAGW-1:0] tag1_q, tag1_d;

    // Stage 2 registers
    logic            v2_q,   v2_d;
    logic [EW-1:0]   sh_q,   sh_d;
    logic            sat_q,  sat_d;
    logic [TAGW-1:0] tag2_q, tag2_d;

    logic          adv2;
    logic          load1;
    logic [EW-1:0] emax;
    logic          below_clamp;

    // An empty S2 always accepts, so bubbles collapse without waiting on out_ready.
    assign adv2     = ~v2_q | out_ready;
    assign load1    = ~v1_q | adv2;
    assign in_ready = load1;

    assign emax        = {{(EW - 10){1'b0}}, {3{db}}, 7'h7F};
    assign below_clamp = $signed(sum_q) < $signed(CLAMP);

    always_comb begin
        // NOTE: every next-state value is defaulted to hold first, so no path leaves a latch.
        v1_d   = v1_q;
        sum_d  = sum_q;
        den_d  = den_q;
        lz_d   = lz_q;
        tag1_d = tag1_q;

        if (load1) begin
            v1_d = in_valid;
            if (in_valid) begin
                sum_d  = er + emax;
                den_d  = tiny & ~unfen;
                lz_d   = {{(EW - LZW){1'b0}}, lz};
                tag1_d = in_tag;
            end
        end
    end

    always_comb begin
        v2_d   = v2_q;
        sh_d   = sh_q;
        sat_d  = sat_q;
        tag2_d = tag2_q;

        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                tag2_d = tag1_q;
                if (den_q && below_clamp) begin
                    sh_d  = CLAMP;
                    sat_d = 1'b1;
                end else if (den_q) begin
                    sh_d  = sum_q;
                    sat_d = 1'b0;
                end else begin
                    sh_d  = lz_q;
                    sat_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            v1_q   <= 1'b0;
            sum_q  <= '0;
            den_q  <= 1'b0;
            lz_q   <= '0;
            tag1_q <= '0;
            v2_q   <= 1'b0;
            sh_q   <= '0;
            sat_q  <= 1'b0;
            tag2_q <= '0;
        end else begin
            v1_q   <= v1_d;
            sum_q  <= sum_d;
            den_q  <= den_d;
            lz_q   <= lz_d;
            tag1_q <= tag1_d;
            v2_q   <= v2_d;
            sh_q   <= sh_d;
            sat_q  <= sat_d;
            tag2_q <= tag2_d;
        end
    end

    assign out_valid = v2_q;
    assign sh        = sh_q;
    assign sh_sat    = sat_q;
    assign out_tag   = tag2_q;

endmodule
